// File: rtl/bootrom_blk_if.sv
// bootrom_blk_if
//   Bundles the command and response signals of the boot memory.
//   master modport: the bus side that issues commands and takes responses.
//   slave modport:  the memory side (bootrom_blk).
//   Signals:
//     cmd_ready  slave->master  memory can accept a command
//     cmd_valid  master->slave  command present
//     cmd_addr   master->slave  byte address (AW bits)
//     cmd_we_msk master->slave  byte-lane write enables, zero means read
//     din        master->slave  write data (DW bits)
//     valid      slave->master  response available
//     ready      master->slave  consumer takes the response
//     dout       slave->master  read data (DW bits)
interface bootrom_blk_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cmd_ready;
  logic            cmd_valid;
  logic [AW-1:0]   cmd_addr;
  logic [DW/8-1:0] cmd_we_msk;
  logic [DW-1:0]   din;
  logic            valid;
  logic            ready;
  logic [DW-1:0]   dout;

  modport master (
    input  cmd_ready, valid, dout,
    output cmd_valid, cmd_addr, cmd_we_msk, din, ready
  );

  modport slave (
    output cmd_ready, valid, dout,
    input  cmd_valid, cmd_addr, cmd_we_msk, din, ready
  );
endinterface

// File: rtl/bootrom_blk.sv
// bootrom_blk
//   Single-port, word-addressed boot memory on the processor fast bus.
//   One read or byte-masked write is accepted per handshake; exactly one
//   response follows one cycle later. At most one response is outstanding.
//   Ports:
//     clk    rising-edge clock for all state
//     rst_n  synchronous active-low reset (clears valid and dout only)
//     bus    bootrom_blk_if.slave: command (cmd_*/din) and response
//            (valid/ready/dout) channels
//   Memory is zero at time zero.
//   Addresses alias modulo SIZE_BYTES; cmd_addr[1:0] is ignored.
module bootrom_blk #(
  parameter int    AW            = 32,
  parameter int    DW            = 32,
  parameter int    SIZE_BYTES    = 4096,
  parameter string MEMH_FILE     = "",
  parameter int    ENABLE_BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  bootrom_blk_if.slave bus
);

  localparam int SIZE_WORDS = SIZE_BYTES / 4;
  localparam int ADDR_BITS  = $clog2(SIZE_WORDS);
  localparam int NLANES     = DW / 8;

  // Elaboration-time parameter sanity checks.
  if (DW != 32) begin : g_chk_dw
    $error("bootrom_blk: DW must be 32");
  end
  if ((SIZE_BYTES < 8) || ((SIZE_BYTES & (SIZE_BYTES - 1)) != 0)) begin : g_chk_size
    $error("bootrom_blk: SIZE_BYTES must be a power of two of at least 8");
  end
  if (AW < ADDR_BITS + 3) begin : g_chk_aw
    $error("bootrom_blk: AW too small for SIZE_BYTES");
  end

  // Storage and registered state.
  logic [DW-1:0] mem_q [SIZE_WORDS];
  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] dout_q;

  // Command decode.
  logic [ADDR_BITS-1:0] word_idx;
  logic                 cmd_ready_c;
  logic                 push;
  logic                 pop;
  logic                 rd_push;
  logic                 wr_push;
  logic [NLANES-1:0]    lane_we;
  logic                 unused_addr_bits;

  assign word_idx = bus.cmd_addr[ADDR_BITS+1:2];

  // Byte offset and bits above the memory size deliberately alias.
  assign unused_addr_bits = ^{bus.cmd_addr[AW-1:ADDR_BITS+2], bus.cmd_addr[1:0]};

  assign push    = bus.cmd_valid & cmd_ready_c;
  assign pop     = valid_q & bus.ready;
  assign wr_push = push & (|bus.cmd_we_msk);
  assign rd_push = push & ~(|bus.cmd_we_msk);

  // With bypass, the slot freed by a pop can be refilled in the same cycle;
  // without it, the block idles one cycle between responses.
  if (ENABLE_BYPASS != 0) begin : g_bypass
    assign cmd_ready_c = ~valid_q | pop;
  end else begin : g_no_bypass
    assign cmd_ready_c = ~valid_q;
  end

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane_we
    assign lane_we[gi] = wr_push & bus.cmd_we_msk[gi];
  end

  // Memory image at time zero: all zeros. Reset never touches the contents.
  initial begin
    for (int i = 0; i < SIZE_WORDS; i++) begin
      mem_q[i] = '0;
    end
  end

  // Response-valid: load-enabled flop, loads push|~pop on any handshake.
  // push+pop together keeps it at 1 (back-to-back bypass).
  always_comb begin
    valid_d = valid_q;
    if (push | pop) begin
      valid_d = push | ~pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Read port. The array is read only inside this clocked block so it maps
  // onto a synchronous RAM with its output register; dout changes only on
  // a read push, so it holds across writes and stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_push) begin
      dout_q <= mem_q[word_idx];
    end
  end

  // Write port with per-lane enables. Not gated by reset, so a write whose
  // push edge coincides with reset still commits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (lane_we[i]) begin
        mem_q[word_idx][i*8 +: 8] <= bus.din[i*8 +: 8];
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.valid     = valid_q;
  assign bus.dout      = dout_q;

endmodule

// File: tb/tb_bootrom_blk.sv
// tb_bootrom_blk
//   Directed bench for bootrom_blk: one instance with bypass enabled and one
//   with bypass disabled, sharing clock and reset.
module tb_bootrom_blk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bootrom_blk_if #(.AW(32), .DW(32)) bus_a ();
  bootrom_blk_if #(.AW(32), .DW(32)) bus_b ();

  bootrom_blk #(
    .AW(32), .DW(32), .SIZE_BYTES(4096), .MEMH_FILE(""), .ENABLE_BYPASS(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  bootrom_blk #(
    .AW(32), .DW(32), .SIZE_BYTES(4096), .MEMH_FILE(""), .ENABLE_BYPASS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command on bus_a for a single edge, then withdraw it.
  task automatic issue_a(input logic [31:0] addr, input logic [3:0] msk, input logic [31:0] data);
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_addr   = addr;
    bus_a.cmd_we_msk = msk;
    bus_a.din        = data;
    tick();
    bus_a.cmd_valid  = 1'b0;
    $display("txn A addr=%h msk=%b din=%h -> valid=%0b dout=%h",
             addr, msk, data, bus_a.valid, bus_a.dout);
  endtask

  logic exp_valid;

  initial begin
    bus_a.cmd_valid = 1'b0; bus_a.cmd_addr = '0; bus_a.cmd_we_msk = '0;
    bus_a.din = '0; bus_a.ready = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_addr = '0; bus_b.cmd_we_msk = '0;
    bus_b.din = '0; bus_b.ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_valid", {31'd0, bus_a.valid}, 32'd0);
    chk("reset_dout", bus_a.dout, 32'h0);
    chk("reset_cmd_ready", {31'd0, bus_a.cmd_ready}, 32'd1);
    chk("reset_valid_b", {31'd0, bus_b.valid}, 32'd0);
    rst_n = 1'b1;
    bus_a.ready = 1'b1;

    // Load word 1 through the write port, then read it back
    issue_a(32'h4, 4'hF, 32'hDEADBEEF);
    chk("wr1_ack_valid", {31'd0, bus_a.valid}, 32'd1);
    chk("wr1_dout_hold", bus_a.dout, 32'h0);
    tick();
    chk("wr1_after_pop_valid", {31'd0, bus_a.valid}, 32'd0);

    issue_a(32'h4, 4'h0, 32'h0);
    chk("rd1_valid", {31'd0, bus_a.valid}, 32'd1);
    chk("rd1_dout", bus_a.dout, 32'hDEADBEEF);
    tick();
    chk("rd1_after_pop_valid", {31'd0, bus_a.valid}, 32'd0);
    chk("rd1_dout_keep", bus_a.dout, 32'hDEADBEEF);

    // Byte-masked write to a zero word
    issue_a(32'h0, 4'b0101, 32'h11223344);
    chk("bw_ack_valid", {31'd0, bus_a.valid}, 32'd1);
    chk("bw_dout_hold", bus_a.dout, 32'hDEADBEEF);
    tick();
    issue_a(32'h0, 4'h0, 32'h0);
    chk("bw_read", bus_a.dout, 32'h00220044);
    tick();

    // Backpressure with a second command waiting
    bus_a.ready = 1'b0;
    issue_a(32'h4, 4'h0, 32'h0);
    chk("bp_valid", {31'd0, bus_a.valid}, 32'd1);
    chk("bp_dout", bus_a.dout, 32'hDEADBEEF);
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_addr   = 32'h0;
    bus_a.cmd_we_msk = 4'h0;
    #1;
    chk("bp_cmd_ready", {31'd0, bus_a.cmd_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_stall%0d_valid", k), {31'd0, bus_a.valid}, 32'd1);
      chk($sformatf("bp_stall%0d_dout", k), bus_a.dout, 32'hDEADBEEF);
      chk($sformatf("bp_stall%0d_cmd_ready", k), {31'd0, bus_a.cmd_ready}, 32'd0);
    end
    bus_a.ready = 1'b1;
    #1;
    chk("bypass_cmd_ready", {31'd0, bus_a.cmd_ready}, 32'd1);
    tick();
    bus_a.cmd_valid = 1'b0;
    $display("txn A bypass read addr=00000000 -> valid=%0b dout=%h", bus_a.valid, bus_a.dout);
    chk("bypass_valid", {31'd0, bus_a.valid}, 32'd1);
    chk("bypass_dout", bus_a.dout, 32'h00220044);
    tick();
    chk("bypass_after_pop_valid", {31'd0, bus_a.valid}, 32'd0);

    // Aliasing modulo 4096 bytes and ignored byte offset
    issue_a(32'h1000, 4'hF, 32'hCAFEF00D);
    tick();
    issue_a(32'h0, 4'h0, 32'h0);
    chk("alias_rd0", bus_a.dout, 32'hCAFEF00D);
    tick();
    issue_a(32'h3, 4'h0, 32'h0);
    chk("alias_rd3", bus_a.dout, 32'hCAFEF00D);
    tick();
    issue_a(32'h1004, 4'h0, 32'h0);
    chk("alias_rd1004", bus_a.dout, 32'hDEADBEEF);
    tick();

    // Reset while a response is pending
    bus_a.ready = 1'b0;
    issue_a(32'h0, 4'h0, 32'h0);
    chk("rst_mid_pending", {31'd0, bus_a.valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", {31'd0, bus_a.valid}, 32'd0);
    chk("rst_mid_dout", bus_a.dout, 32'h0);
    rst_n = 1'b1;
    bus_a.ready = 1'b1;
    tick();

    // Bypass disabled: command and ready held high
    bus_b.ready      = 1'b1;
    bus_b.cmd_addr   = 32'h0;
    bus_b.cmd_we_msk = 4'h0;
    bus_b.cmd_valid  = 1'b1;
    #1;
    chk("nb_initial_cmd_ready", {31'd0, bus_b.cmd_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_valid = ((k % 2) == 0);
      $display("txn B cycle=%0d -> valid=%0b cmd_ready=%0b", k, bus_b.valid, bus_b.cmd_ready);
      chk($sformatf("nb_cyc%0d_valid", k), {31'd0, bus_b.valid}, {31'd0, exp_valid});
      chk($sformatf("nb_cyc%0d_cmd_ready", k), {31'd0, bus_b.cmd_ready}, {31'd0, ~exp_valid});
    end
    bus_b.cmd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
